// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//
// Groups the fetch-lookup and branch-resolve signals of the branch predictor.
//
// Handshake: there is no back-pressure. A resolve is accepted on every rising
// clock edge where resolve_valid=1, and resolve_* must be stable around that
// edge. flush_pipeline is a one-cycle registered pulse, and true_address is
// meaningful while flush_pipeline=1.
//
// Signals:
//   fetch_PC            -> predictor  PC being fetched this cycle
//   prediction          <- predictor  1 = predicted taken
//   BTB_address         <- predictor  predicted target (0 if not taken)
//   resolve_valid       -> predictor  a branch resolves this cycle
//   resolve_PC          -> predictor  address of resolving branch
//   resolve_taken       -> predictor  actual outcome
//   resolve_target      -> predictor  actual taken target
//   resolve_pred_taken  -> predictor  direction predicted at fetch
//   resolve_pred_target -> predictor  target predicted at fetch
//   flush_pipeline      <- predictor  mispredict pulse
//   true_address        <- predictor  correct next PC
//   stat_*              <- predictor  statistics (only with BP_STATS_EN)
//
// master = pipeline side, slave = predictor.
interface branch_predictor_if;
    logic [31:0] fetch_PC;
    logic        prediction;
    logic [31:0] BTB_address;
    logic        resolve_valid;
    logic [31:0] resolve_PC;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic        flush_pipeline;
    logic [31:0] true_address;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic [31:0] stat_btb_hits;
`endif

    modport master (
        output fetch_PC, resolve_valid, resolve_PC, resolve_taken,
               resolve_target, resolve_pred_taken, resolve_pred_target,
        input  prediction, BTB_address, flush_pipeline, true_address
`ifdef BP_STATS_EN
        , input stat_branches, stat_mispredicts, stat_btb_hits
`endif
    );

    modport slave (
        input  fetch_PC, resolve_valid, resolve_PC, resolve_taken,
               resolve_target, resolve_pred_taken, resolve_pred_target,
        output prediction, BTB_address, flush_pipeline, true_address
`ifdef BP_STATS_EN
        , output stat_branches, stat_mispredicts, stat_btb_hits
`endif
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
//
// Direct-mapped BTB with 2-bit saturating counters, looked up combinationally
// with fetch_PC and updated at the edge where a branch resolves. A resolve
// whose fetch-time prediction was wrong produces a registered one-cycle
// flush_pipeline pulse together with the correct next PC in true_address.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   bp     branch_predictor_if.slave (lookup, resolve, flush, optional stats)
//
// Parameters:
//   ENTRIES  BTB entries, power of two, 2..256
//   IDX_W    index width, $clog2(ENTRIES)
//
// Optional feature macro: BP_STATS_EN adds saturating counters of resolves,
// mispredicts and BTB hits on resolve.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
);
    localparam int TAG_W = 32 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic             flush_q;
    logic [31:0]      true_q;

    // Lookup: reads the registered table, so a same-cycle update to the same
    // entry is not visible until after the edge.
    logic [IDX_W-1:0] f_idx;
    logic             f_hit;
    logic             f_pred;

    assign f_idx  = bp.fetch_PC[IDX_W-1:0];
    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == bp.fetch_PC[31:IDX_W]);
    assign f_pred = f_hit && ctr_q[f_idx][1];

    assign bp.prediction  = f_pred;
    assign bp.BTB_address = f_pred ? target_q[f_idx] : 32'd0;

    // Resolve side
    logic [IDX_W-1:0] r_idx;
    logic             r_hit;
    logic             mispredict;
    logic [31:0]      correct_pc;

    assign r_idx = bp.resolve_PC[IDX_W-1:0];
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == bp.resolve_PC[31:IDX_W]);

    // A right direction with a wrong target only matters when both say taken.
    assign mispredict = bp.resolve_valid &&
                        ((bp.resolve_pred_taken != bp.resolve_taken) ||
                         (bp.resolve_taken && bp.resolve_pred_taken &&
                          (bp.resolve_pred_target != bp.resolve_target)));

    assign correct_pc = bp.resolve_taken ? bp.resolve_target
                                         : bp.resolve_PC + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'd1;   // weakly not taken
            end
        end else if (bp.resolve_valid) begin
            if (r_hit) begin
                if (bp.resolve_taken) begin
                    ctr_q[r_idx]    <= (ctr_q[r_idx] == 2'd3) ? 2'd3 : ctr_q[r_idx] + 2'd1;
                    target_q[r_idx] <= bp.resolve_target;
                end else begin
                    ctr_q[r_idx]    <= (ctr_q[r_idx] == 2'd0) ? 2'd0 : ctr_q[r_idx] - 2'd1;
                end
            end else if (bp.resolve_taken) begin
                // Allocation evicts whatever branch aliased to this index.
                valid_q[r_idx]  <= 1'b1;
                tag_q[r_idx]    <= bp.resolve_PC[31:IDX_W];
                target_q[r_idx] <= bp.resolve_target;
                ctr_q[r_idx]    <= 2'd2;   // weakly taken
            end
        end
    end

    // true_address only loads on a mispredict so it holds between flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q <= 1'b0;
            true_q  <= 32'd0;
        end else begin
            flush_q <= mispredict;
            if (mispredict) begin
                true_q <= correct_pc;
            end
        end
    end

    assign bp.flush_pipeline = flush_q;
    assign bp.true_address   = true_q;

`ifdef BP_STATS_EN
    logic [31:0] st_br_q;
    logic [31:0] st_mp_q;
    logic [31:0] st_hit_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_br_q  <= 32'd0;
            st_mp_q  <= 32'd0;
            st_hit_q <= 32'd0;
        end else begin
            if (bp.resolve_valid && (st_br_q != 32'hFFFF_FFFF)) begin
                st_br_q <= st_br_q + 32'd1;
            end
            if (mispredict && (st_mp_q != 32'hFFFF_FFFF)) begin
                st_mp_q <= st_mp_q + 32'd1;
            end
            if (bp.resolve_valid && r_hit && (st_hit_q != 32'hFFFF_FFFF)) begin
                st_hit_q <= st_hit_q + 32'd1;
            end
            if (mispredict) begin
                $display("branch_predictor stats: branches=%0d mispredicts=%0d btb_hits=%0d",
                         st_br_q, st_mp_q, st_hit_q);
            end
        end
    end

    assign bp.stat_branches    = st_br_q;
    assign bp.stat_mispredicts = st_mp_q;
    assign bp.stat_btb_hits    = st_hit_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//
// Drives lookups and resolves into branch_predictor and compares its outputs
// with a behavioural model that keeps, per BTB slot, the full PC of the owning
// branch, its target and an integer confidence counter.
module tb_branch_predictor;
    localparam int ENTRIES = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_true;

    // scoreboard: {flush, true_address} expected after the next edge
    logic [32:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = 32'd0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 1;
        end
        m_true = 32'd0;
        exp_q.delete();
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int s;
        s = int'(pc % ENTRIES);
        return m_valid[s] && ((m_pc[s] / ENTRIES) == (pc / ENTRIES));
    endfunction

    function automatic void model_lookup(input logic [31:0] pc,
                                         output logic p, output logic [31:0] a);
        int s;
        s = int'(pc % ENTRIES);
        p = model_hit(pc) && (m_ctr[s] >= 2);
        a = p ? m_tgt[s] : 32'd0;
    endfunction

    function automatic void model_resolve(input logic [31:0] rpc, input logic rt,
                                          input logic [31:0] rtg, input logic rpt,
                                          input logic [31:0] rptg);
        int s;
        bit mis;
        s   = int'(rpc % ENTRIES);
        mis = (rpt != rt) || (rt && rpt && (rptg != rtg));
        if (mis) m_true = rt ? rtg : rpc + 32'd1;
        exp_q.push_back({mis, m_true});
        if (model_hit(rpc)) begin
            if (rt) begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = rtg;
            end else begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (rt) begin
            m_valid[s] = 1'b1;
            m_pc[s]    = rpc;
            m_tgt[s]   = rtg;
            m_ctr[s]   = 2;
        end
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic drive_cycle(input logic [31:0] fpc, input logic rv,
                               input logic [31:0] rpc, input logic rt,
                               input logic [31:0] rtg, input logic rpt,
                               input logic [31:0] rptg);
        logic        ep;
        logic [31:0] ea;
        logic [32:0] e;
        bp.fetch_PC            = fpc;
        bp.resolve_valid       = rv;
        bp.resolve_PC          = rpc;
        bp.resolve_taken       = rt;
        bp.resolve_target      = rtg;
        bp.resolve_pred_taken  = rpt;
        bp.resolve_pred_target = rptg;
        @(negedge clk);
        model_lookup(fpc, ep, ea);
        check("prediction", {31'd0, bp.prediction}, {31'd0, ep});
        check("btb_address", bp.BTB_address, ea);
        if (rv) model_resolve(rpc, rt, rtg, rpt, rptg);
        else    exp_q.push_back({1'b0, m_true});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("flush", {31'd0, bp.flush_pipeline}, {31'd0, e[32]});
        check("true_address", bp.true_address, e[31:0]);
    endtask

    task automatic idle_fetch(input logic [31:0] fpc);
        drive_cycle(fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        p;
        logic [31:0] a;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtg;
        total = 0;
        bad   = 0;
        bp.fetch_PC = 0; bp.resolve_valid = 0; bp.resolve_PC = 0;
        bp.resolve_taken = 0; bp.resolve_target = 0;
        bp.resolve_pred_taken = 0; bp.resolve_pred_target = 0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flush", {31'd0, bp.flush_pipeline}, 32'd0);
        check("reset_true", bp.true_address, 32'd0);
        reset = 1'b0;

        // cold taken branch with same-cycle lookup of the same PC
        drive_cycle(32'd5, 1'b1, 32'd5, 1'b1, 32'd12, 1'b0, 32'd0);
        idle_fetch(32'd5);
        // saturate, then two not-taken resolves
        drive_cycle(32'd5, 1'b1, 32'd5, 1'b1, 32'd12, 1'b1, 32'd12);
        drive_cycle(32'd5, 1'b1, 32'd5, 1'b1, 32'd12, 1'b1, 32'd12);
        drive_cycle(32'd5, 1'b1, 32'd5, 1'b0, 32'd0, 1'b1, 32'd12);
        drive_cycle(32'd5, 1'b1, 32'd5, 1'b0, 32'd0, 1'b1, 32'd12);
        idle_fetch(32'd5);
        // wrong target
        drive_cycle(32'd5, 1'b1, 32'd5, 1'b1, 32'd14, 1'b1, 32'd12);
        idle_fetch(32'd5);
        // aliasing: PC 21 evicts PC 5
        drive_cycle(32'd5, 1'b1, 32'd21, 1'b1, 32'd3, 1'b0, 32'd0);
        idle_fetch(32'd5);
        idle_fetch(32'd21);
        // PC wrap on the not-taken path
        drive_cycle(32'd21, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 32'd7);
        idle_fetch(32'hFFFF_FFFF);

        // reset while a flush is pending
        drive_cycle(32'd21, 1'b1, 32'd9, 1'b1, 32'd40, 1'b0, 32'd0);
        check("pre_reset_flush", {31'd0, bp.flush_pipeline}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_flush", {31'd0, bp.flush_pipeline}, 32'd0);
        check("async_reset_true", bp.true_address, 32'd0);
        bp.fetch_PC = 32'd21;
        #1;
        check("async_reset_pred", {31'd0, bp.prediction}, 32'd0);
        check("async_reset_btb", bp.BTB_address, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // randomized traffic on a small PC range to force hits and aliasing
        for (int n = 0; n < 400; n++) begin
            rpc = 32'($urandom_range(0, 47));
            rt  = 1'($urandom_range(0, 1));
            rtg = 32'($urandom_range(0, 255));
            model_lookup(rpc, p, a);
            if ($urandom_range(0, 3) == 0) begin
                p = ~p;
                a = 32'($urandom_range(0, 255));
            end
            drive_cycle(32'($urandom_range(0, 47)), 1'($urandom_range(0, 3) != 0),
                        rpc, rt, rtg, p, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
